// File: rtl/superh16_l2_miss_ctrl.sv
// L2 miss controller: optional dirty-victim writeback, line fetch from memory/L3,
// then a single-cycle fill strobe. One miss outstanding at a time.
module superh16_l2_miss_ctrl #(
    parameter int ADDR_WIDTH     = 48,
    parameter int LINE_BITS      = 512,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  miss_is_icache,
    input  logic [2:0]            victim_way,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [LINE_BITS-1:0]  victim_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_BITS-1:0]  mem_rdata,
    output logic                  fill_valid,
    output logic [2:0]            fill_way,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_BITS-1:0]  fill_data,
    output logic                  fill_is_icache,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
);

    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

    state_t                 state_reg;
    logic [ADDR_WIDTH-1:0]  miss_addr_reg;
    logic [ADDR_WIDTH-1:0]  victim_addr_reg;
    logic [LINE_BITS-1:0]   victim_data_reg;
    logic [LINE_BITS-1:0]   fill_data_reg;
    logic [2:0]             way_reg;
    logic                   is_icache_reg;
    logic [WAIT_W-1:0]      wait_cnt_reg;
    logic [WAIT_W-1:0]      wait_cnt_next;
    logic                   timeout_err_reg;
    logic [31:0]            miss_count_reg;
    logic [31:0]            wb_count_reg;
    logic [ADDR_WIDTH-1:0]  miss_addr_aligned;
    logic [ADDR_WIDTH-1:0]  victim_addr_aligned;

    // Offset bits are cleared once at capture so every later use is already aligned.
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
        if (gi < OFFSET_BITS) begin : g_off
            assign miss_addr_aligned[gi]   = 1'b0;
            assign victim_addr_aligned[gi] = 1'b0;
        end else begin : g_keep
            assign miss_addr_aligned[gi]   = miss_addr[gi];
            assign victim_addr_aligned[gi] = victim_addr[gi];
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (wait_cnt_reg != WAIT_MAX)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            miss_addr_reg   <= '0;
            victim_addr_reg <= '0;
            victim_data_reg <= '0;
            fill_data_reg   <= '0;
            way_reg         <= '0;
            is_icache_reg   <= 1'b0;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
            miss_count_reg  <= '0;
            wb_count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_valid) begin
                        miss_addr_reg   <= miss_addr_aligned;
                        victim_addr_reg <= victim_addr_aligned;
                        victim_data_reg <= victim_data;
                        way_reg         <= victim_way;
                        is_icache_reg   <= miss_is_icache;
                        miss_count_reg  <= miss_count_reg + 32'd1;
                        wait_cnt_reg    <= '0;
                        state_reg       <= victim_dirty ? WB : FETCH;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        wb_count_reg <= wb_count_reg + 32'd1;
                        wait_cnt_reg <= '0;
                        state_reg    <= FETCH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next == WAIT_MAX)
                            timeout_err_reg <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        fill_data_reg <= mem_rdata;
                        state_reg     <= FILL;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next == WAIT_MAX)
                            timeout_err_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign miss_ready     = (state_reg == IDLE);
    assign busy           = (state_reg != IDLE);
    assign mem_req        = (state_reg == WB) || (state_reg == FETCH);
    assign mem_we         = (state_reg == WB);
    assign mem_addr       = (state_reg == WB)    ? victim_addr_reg :
                            (state_reg == FETCH) ? miss_addr_reg   : '0;
    assign mem_wdata      = (state_reg == WB) ? victim_data_reg : '0;
    assign fill_valid     = (state_reg == FILL);
    assign fill_way       = fill_valid ? way_reg       : '0;
    assign fill_addr      = fill_valid ? miss_addr_reg : '0;
    assign fill_data      = fill_valid ? fill_data_reg : '0;
    assign fill_is_icache = fill_valid & is_icache_reg;
    assign timeout_err    = timeout_err_reg;
    assign miss_count     = miss_count_reg;
    assign wb_count       = wb_count_reg;

endmodule
